tinker_exec_unit: RTL and testbench

Parametrised, multi-cycle integer execute unit for the Tinker core family, replacing the inline ALU case statement with a standalone block that has a valid/ready handshake on both sides. Single-cycle ops (add, sub, logic, shifts) sit beside iterative radix-2 multiply and restoring divide, which take WIDTH cycles each. A destination tag is carried through with each operation so the issuing control FSM can retire results to the register file. Sits between operand read and write-back.

---
 rtl/tinker_exec_unit_if.sv | 29 ++
 rtl/tinker_exec_unit.sv | 177 +++++++++++++++++
 tb/tb_tinker_exec_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinker_exec_unit_if.sv
// rtl/tinker_exec_unit_if.sv - issue/result handshake bundle for the Tinker execute unit
// master = issuing control FSM, slave = execute unit.
interface tinker_exec_unit_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_error;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_error, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_error, busy
    );
endinterface

// File: rtl/tinker_exec_unit.sv
// rtl/tinker_exec_unit.sv - multi-cycle integer execute unit with tag pass-through
// Single-cycle ALU ops finish on accept; MUL/DIV iterate one bit per cycle.
module tinker_exec_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    tinker_exec_unit_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             error_q, error_d;

    logic             accept;
    logic             shift_oob;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_result;
    logic             alu_error;
    logic             last_iter;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;

    assign accept    = bus.in_valid && (state_q == S_IDLE);
    assign shift_oob = |bus.in_b[WIDTH-1:SH_W];
    assign shamt     = bus.in_b[SH_W-1:0];
    assign last_iter = (cnt_q == SH_W'(WIDTH - 1));

    // MUL: a_q shifts left and b_q right, so b_q[0] is always the current multiplier bit.
    assign mul_acc_next = b_q[0] ? (acc_q + a_q) : acc_q;

    // DIV: acc_q is the partial remainder, a_q shifts the dividend out and the quotient in.
    assign rem_shift = {acc_q, a_q[WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, b_q};
    assign div_ge    = !rem_sub[WIDTH];
    assign rem_next  = div_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_next = {a_q[WIDTH-2:0], div_ge};

    always_comb begin
        alu_result = '0;
        alu_error  = 1'b0;
        case (bus.in_op)
            OP_ADD:         alu_result = bus.in_a + bus.in_b;
            OP_SUB:         alu_result = bus.in_a - bus.in_b;
            OP_AND:         alu_result = bus.in_a & bus.in_b;
            OP_OR:          alu_result = bus.in_a | bus.in_b;
            OP_XOR:         alu_result = bus.in_a ^ bus.in_b;
            OP_NOT:         alu_result = ~bus.in_a;
            OP_SHR:         alu_result = shift_oob ? '0 : (bus.in_a >> shamt);
            OP_SHL:         alu_result = shift_oob ? '0 : (bus.in_a << shamt);
            OP_MUL, OP_DIV: alu_result = '0;
            default:        alu_error  = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    tag_d = bus.in_tag;
                    acc_d = '0;
                    cnt_d = '0;
                    if (bus.in_op == OP_MUL) begin
                        error_d = 1'b0;
                        state_d = S_MUL;
                    end else if (bus.in_op == OP_DIV) begin
                        if (bus.in_b == '0) begin
                            result_d = '0;
                            error_d  = 1'b1;
                            state_d  = S_DONE;
                        end else begin
                            error_d = 1'b0;
                            state_d = S_DIV;
                        end
                    end else begin
                        result_d = alu_result;
                        error_d  = alu_error;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + SH_W'(1);
                if (last_iter) begin
                    result_d = mul_acc_next;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = rem_next;
                a_d   = quot_next;
                cnt_d = cnt_q + SH_W'(1);
                if (last_iter) begin
                    result_d = quot_next;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            tag_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            error_q  <= error_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
    assign bus.out_error  = error_q;
endmodule

// File: tb/tb_tinker_exec_unit.sv
// tb/tb_tinker_exec_unit.sv - self-checking bench for tinker_exec_unit (WIDTH 64 and 8)
module tb_tinker_exec_unit;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tinker_exec_unit_if #(.WIDTH(64), .TAG_W(5)) bus64 ();
    tinker_exec_unit_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

    tinker_exec_unit #(.WIDTH(64), .TAG_W(5)) dut64 (.clk(clk), .reset(rst_n), .bus(bus64.slave));
    tinker_exec_unit #(.WIDTH(8),  .TAG_W(5)) dut8  (.clk(clk), .reset(rst_n), .bus(bus8.slave));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions, truncated to w bits.
    function automatic void calc(input int w, input logic [3:0] op, input logic [63:0] a_in,
                                 input logic [63:0] b_in, output logic [63:0] res, output logic err);
        logic [63:0] mask, a, b;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        res = '0;
        err = 1'b0;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_MUL: res = a * b;
            OP_DIV: if (b == 0) err = 1'b1; else res = a / b;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHR: res = (b >= 64'(w)) ? 64'd0 : (a >> b);
            OP_SHL: res = (b >= 64'(w)) ? 64'd0 : (a << b);
            default: err = 1'b1;
        endcase
        res = res & mask;
    endfunction

    // Model state per unit (0 = WIDTH 64, 1 = WIDTH 8): one outstanding op and when it is due.
    bit          pend [2];
    bit          is_long [2];
    longint      done_cyc [2];
    logic [63:0] exp_res [2];
    logic [4:0]  exp_tag [2];
    logic        exp_err [2];
    longint      cyc = 0;

    task automatic model_step(input int u, input logic iv, input logic [3:0] op, input logic [63:0] a,
                              input logic [63:0] b, input logic [4:0] tag, input logic ordy);
        int w;
        logic [63:0] r;
        logic e;
        w = (u == 0) ? 64 : 8;
        if (pend[u] && (cyc - 1) >= done_cyc[u] && ordy) begin
            pend[u] = 1'b0;
        end else if (!pend[u] && iv) begin
            calc(w, op, a, b, r, e);
            pend[u]     = 1'b1;
            exp_res[u]  = r;
            exp_err[u]  = e;
            exp_tag[u]  = tag;
            is_long[u]  = (op == OP_MUL) || (op == OP_DIV && !e);
            done_cyc[u] = cyc + (is_long[u] ? longint'(w) : 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
            end else begin
                cyc++;
                model_step(0, bus64.in_valid, bus64.in_op, bus64.in_a, bus64.in_b, bus64.in_tag, bus64.out_ready);
                model_step(1, bus8.in_valid, bus8.in_op, {56'd0, bus8.in_a}, {56'd0, bus8.in_b}, bus8.in_tag,
                           bus8.out_ready);
            end
        end
    end

    task automatic cmp_unit(input int u, input logic ir, input logic ov, input logic bz,
                            input logic [63:0] res, input logic [4:0] tag, input logic err);
        bit ev;
        ev = pend[u] && cyc >= done_cyc[u];
        chk($sformatf("u%0d in_ready cyc %0d", u, cyc), ir, !pend[u]);
        chk($sformatf("u%0d out_valid cyc %0d", u, cyc), ov, ev);
        chk($sformatf("u%0d busy cyc %0d", u, cyc), bz, pend[u] && is_long[u] && cyc < done_cyc[u]);
        if (ev) begin
            chk($sformatf("u%0d out_result cyc %0d", u, cyc), res, exp_res[u]);
            chk($sformatf("u%0d out_tag cyc %0d", u, cyc), tag, exp_tag[u]);
            chk($sformatf("u%0d out_error cyc %0d", u, cyc), err, exp_err[u]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cmp_unit(0, bus64.in_ready, bus64.out_valid, bus64.busy, bus64.out_result, bus64.out_tag,
                         bus64.out_error);
                cmp_unit(1, bus8.in_ready, bus8.out_valid, bus8.busy, {56'd0, bus8.out_result}, bus8.out_tag,
                         bus8.out_error);
            end
        end
    end

    task automatic run_op(input int u, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] tag, output logic [63:0] res, output logic err,
                          output logic [4:0] otag, output int lat, output int nbusy);
        bit seen;
        seen = 1'b0; lat = 0; nbusy = 0; res = '0; err = 1'b0; otag = '0;
        @(negedge clk);
        if (u == 0) begin
            bus64.in_valid = 1'b1; bus64.in_op = op; bus64.in_a = a; bus64.in_b = b; bus64.in_tag = tag;
        end else begin
            bus8.in_valid = 1'b1; bus8.in_op = op; bus8.in_a = a[7:0]; bus8.in_b = b[7:0]; bus8.in_tag = tag;
        end
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (u == 0) begin
                bus64.in_valid = 1'b0;
                if (bus64.busy) nbusy++;
                if (bus64.out_valid) begin
                    seen = 1'b1; res = bus64.out_result; err = bus64.out_error; otag = bus64.out_tag;
                end
            end else begin
                bus8.in_valid = 1'b0;
                if (bus8.busy) nbusy++;
                if (bus8.out_valid) begin
                    seen = 1'b1; res = {56'd0, bus8.out_result}; err = bus8.out_error; otag = bus8.out_tag;
                end
            end
        end
        chk("result arrives within bound", seen, 1'b1);
    endtask

    task automatic consume(input int u);
        if (u == 0) bus64.out_ready = 1'b1; else bus8.out_ready = 1'b1;
        @(negedge clk);
        if (u == 0) begin
            bus64.out_ready = 1'b0;
            chk("handoff out_valid drops", bus64.out_valid, 1'b0);
            chk("handoff in_ready rises", bus64.in_ready, 1'b1);
        end else begin
            bus8.out_ready = 1'b0;
            chk("handoff8 out_valid drops", bus8.out_valid, 1'b0);
            chk("handoff8 in_ready rises", bus8.in_ready, 1'b1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic e;
        logic [4:0] t;
        int lat, nb, cnt;

        rst_n = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_op = '0; bus64.in_a = '0; bus64.in_b = '0; bus64.in_tag = '0;
        bus64.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_op = '0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_tag = '0;
        bus8.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", bus64.out_valid, 1'b0);
        chk("reset out_result", bus64.out_result, 64'd0);
        chk("reset out_tag", bus64.out_tag, 5'd0);
        chk("reset out_error", bus64.out_error, 1'b0);
        chk("reset busy", bus64.busy, 1'b0);
        chk("reset8 out_valid", bus8.out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", bus64.in_ready, 1'b1);
        chk("post-reset in_ready8", bus8.in_ready, 1'b1);

        calc(64, OP_ADD, '1, 64'd2, r, e);             chk("model add wrap", r, 64'd1);
        calc(8, OP_MUL, 64'd15, 64'd17, r, e);         chk("model mul8", r, 64'hFF);
        calc(64, OP_DIV, 64'd100, 64'd7, r, e);        chk("model div", r, 64'd14);
        calc(8, OP_SHL, 64'd1, 64'd8, r, e);           chk("model shl oob", r, 64'd0);
        calc(64, 4'd12, 64'd1, 64'd1, r, e);           chk("model illegal err", e, 1'b1);

        run_op(0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, r, e, t, lat, nb);
        chk("add wrap result", r, 64'd1); chk("add wrap tag", t, 5'd7);
        chk("add wrap error", e, 1'b0);   chk("add latency", lat, 1);
        consume(0);
        run_op(0, OP_SUB, 64'd0, 64'd1, 5'd1, r, e, t, lat, nb);
        chk("sub borrow result", r, 64'hFFFF_FFFF_FFFF_FFFF);
        consume(0);

        run_op(0, OP_MUL, 64'h1_0000_0001, 64'h10, 5'd2, r, e, t, lat, nb);
        chk("mul result", r, 64'h10_0000_0010); chk("mul latency", lat, 65); chk("mul busy cycles", nb, 64);
        consume(0);
        run_op(0, OP_DIV, 64'd100, 64'd7, 5'd3, r, e, t, lat, nb);
        chk("div 100/7", r, 64'd14); chk("div latency", lat, 65); chk("div busy cycles", nb, 64);
        consume(0);
        run_op(0, OP_DIV, 64'd5, 64'd9, 5'd4, r, e, t, lat, nb);
        chk("div 5/9", r, 64'd0); chk("div 5/9 error", e, 1'b0);
        consume(0);

        run_op(0, OP_DIV, 64'd42, 64'd0, 5'd5, r, e, t, lat, nb);
        chk("div0 error", e, 1'b1); chk("div0 result", r, 64'd0); chk("div0 latency", lat, 1);
        consume(0);
        run_op(0, 4'd12, 64'd3, 64'd4, 5'd6, r, e, t, lat, nb);
        chk("illegal op error", e, 1'b1); chk("illegal op result", r, 64'd0);
        consume(0);

        run_op(0, OP_SHL, 64'd1, 64'd63, 5'd8, r, e, t, lat, nb);
        chk("shl 63", r, 64'h8000_0000_0000_0000);
        consume(0);
        run_op(0, OP_SHR, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 5'd9, r, e, t, lat, nb);
        chk("shr 64", r, 64'd0);
        consume(0);
        run_op(0, OP_SHL, 64'd1, 64'h100, 5'd10, r, e, t, lat, nb);
        chk("shl 0x100", r, 64'd0);
        consume(0);
        run_op(0, OP_NOT, 64'h0F0F, 64'hDEAD, 5'd11, r, e, t, lat, nb);
        chk("not", r, 64'hFFFF_FFFF_FFFF_F0F0);
        consume(0);

        run_op(0, OP_XOR, 64'hF0, 64'hFF, 5'd3, r, e, t, lat, nb);
        chk("xor result", r, 64'h0F);
        bus64.in_valid = 1'b1; bus64.in_op = OP_ADD; bus64.in_a = 64'd1; bus64.in_b = 64'd1; bus64.in_tag = 5'd9;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus64.out_valid && bus64.out_result == 64'h0F && bus64.out_tag == 5'd3 && !bus64.in_ready) cnt++;
        end
        chk("backpressure hold cycles", cnt, 20);
        bus64.in_valid = 1'b0;
        consume(0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus64.out_valid) cnt++;
        end
        chk("no result after handoff", cnt, 0);

        run_op(1, OP_MUL, 64'd15, 64'd17, 5'd12, r, e, t, lat, nb);
        chk("mul8 result", r, 64'hFF); chk("mul8 latency", lat, 9); chk("mul8 busy", nb, 8);
        consume(1);
        run_op(1, OP_DIV, 64'd200, 64'd7, 5'd13, r, e, t, lat, nb);
        chk("div8 200/7", r, 64'd28);
        consume(1);
        run_op(1, OP_ADD, 64'hFF, 64'd2, 5'd14, r, e, t, lat, nb);
        chk("add8 wrap", r, 64'd1);
        consume(1);
        run_op(1, OP_SHL, 64'd1, 64'd8, 5'd15, r, e, t, lat, nb);
        chk("shl8 oob", r, 64'd0);
        consume(1);

        @(negedge clk);
        bus64.in_valid = 1'b1; bus64.in_op = OP_MUL; bus64.in_a = 64'd3; bus64.in_b = 64'd5; bus64.in_tag = 5'd4;
        @(negedge clk);
        bus64.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid-mul busy", bus64.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset mid-mul out_valid", bus64.out_valid, 1'b0);
        chk("reset mid-mul busy", bus64.busy, 1'b0);
        chk("reset mid-mul out_result", bus64.out_result, 64'd0);
        chk("reset mid-mul out_tag", bus64.out_tag, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus64.out_valid || !bus64.in_ready) cnt++;
        end
        chk("no stale result after reset", cnt, 0);
        run_op(0, OP_OR, 64'hF0, 64'h0F, 5'd17, r, e, t, lat, nb);
        chk("or after reset", r, 64'hFF); chk("or tag", t, 5'd17);
        consume(0);
        run_op(0, OP_AND, 64'hF0F0, 64'hFF00, 5'd18, r, e, t, lat, nb);
        chk("and", r, 64'hF000);
        consume(0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
